minilogix2: RTL and testbench

Second-generation freely programmable logic block: an NIN-input / NOUT-output LUT with per-input feedback selection. It adds a per-output toggle (T-flip-flop) mode and double-buffered configuration: a shadow chain is loaded serially on the system clock and committed atomically. Bit-count checking rejects short loads, and a serial output supports daisy-chaining and readback. It sits where minilogix1 sits and shares its clock domain, so there is no separate load clock.

---
 rtl/minilogix_pkg.sv | 38 +++
 rtl/minilogix2_if.sv | 25 ++
 rtl/minilogix2_cfg.sv | 54 +++++
 rtl/minilogix2.sv | 61 ++++++
 tb/tb_minilogix2.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/minilogix_pkg.sv
// Shared sizing helpers for the minilogix2 programmable logic block.
// Config word layout, LSB first: LUT | input select | toggle mode.
package minilogix_pkg;

  localparam int LUT_OFS  = 0;
  localparam int DEF_NIN  = 4;
  localparam int DEF_NOUT = 4;

  function automatic int ncfg_of(input int nin, input int nout);
    return (nin < nout) ? nin : nout;
  endfunction

  function automatic int lut_bits(input int nin, input int nout);
    return nout * (1 << nin);
  endfunction

  function automatic int sel_ofs(input int nin, input int nout);
    return LUT_OFS + lut_bits(nin, nout);
  endfunction

  function automatic int tog_ofs(input int nin, input int nout);
    return sel_ofs(nin, nout) + ncfg_of(nin, nout);
  endfunction

  function automatic int cfg_width(input int nin, input int nout);
    return lut_bits(nin, nout) + ncfg_of(nin, nout) + nout;
  endfunction

  function automatic int cnt_width(input int nin, input int nout);
    return $clog2(cfg_width(nin, nout) + 1);
  endfunction

  localparam int DEF_SEL_OFS = sel_ofs(DEF_NIN, DEF_NOUT);
  localparam int DEF_TOG_OFS = tog_ofs(DEF_NIN, DEF_NOUT);
  localparam int DEF_CFGW    = cfg_width(DEF_NIN, DEF_NOUT);
  localparam int DEF_CNTW    = cnt_width(DEF_NIN, DEF_NOUT);

endpackage

// File: rtl/minilogix2_if.sv
// Logic, load and status signals of minilogix2; clk/rst stay separate.
interface minilogix2_if #(
  parameter int NIN  = 4,
  parameter int NOUT = 4
);
  logic [NIN-1:0]  i_input;
  logic [NOUT-1:0] o_output;
  logic            i_run;
  logic            i_load_en;
  logic            i_load_dat;
  logic            o_load_dat;
  logic            i_commit;
  logic            o_cfg_valid;
  logic            o_cfg_err;

  modport slave (
    input  i_input, i_run, i_load_en, i_load_dat, i_commit,
    output o_output, o_load_dat, o_cfg_valid, o_cfg_err
  );

  modport master (
    output i_input, i_run, i_load_en, i_load_dat, i_commit,
    input  o_output, o_load_dat, o_cfg_valid, o_cfg_err
  );
endinterface

// File: rtl/minilogix2_cfg.sv
// Double-buffered configuration: serial shadow chain, bit counter,
// length-checked commit into the active register.
module minilogix2_cfg
  import minilogix_pkg::*;
#(
  parameter  int NIN  = 4,
  parameter  int NOUT = 4,
  localparam int CFGW = cfg_width(NIN, NOUT),
  localparam int CW   = cnt_width(NIN, NOUT)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_en,
  input  logic            load_dat,
  input  logic            commit,
  output logic [CFGW-1:0] active,
  output logic            cfg_valid,
  output logic            cfg_err,
  output logic            load_out
);

  logic [CFGW-1:0] shadow;
  logic [CW-1:0]   cnt;
  logic            full;

  assign full     = (cnt == CW'(CFGW));
  assign load_out = shadow[CFGW-1];

  always_ff @(posedge clk or posedge rst)
    if (rst)          shadow <= '0;
    else if (load_en) shadow <= {shadow[CFGW-2:0], load_dat};

  // A commit sees the pre-shift count; a bit shifted alongside it starts the next load.
  always_ff @(posedge clk or posedge rst)
    if (rst)                   cnt <= '0;
    else if (commit)           cnt <= load_en ? CW'(1) : '0;
    else if (load_en && !full) cnt <= cnt + 1'b1;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      active    <= '0;
      cfg_valid <= 1'b0;
      cfg_err   <= 1'b0;
    end else if (commit) begin
      if (full) begin
        active    <= shadow;
        cfg_valid <= 1'b1;
        cfg_err   <= 1'b0;
      end else begin
        cfg_err   <= 1'b1;
      end
    end

endmodule

// File: rtl/minilogix2.sv
// Programmable NIN-in / NOUT-out LUT with output feedback and per-output
// toggle mode; configuration handled by minilogix2_cfg.
module minilogix2
  import minilogix_pkg::*;
#(
  parameter int NIN  = 4,
  parameter int NOUT = 4
) (
  input logic           clk,
  input logic           rst,
  minilogix2_if.slave   bus
);

  localparam int CFGW  = cfg_width(NIN, NOUT);
  localparam int NCFG  = ncfg_of(NIN, NOUT);
  localparam int NLUT  = lut_bits(NIN, NOUT);
  localparam int SEL_O = sel_ofs(NIN, NOUT);
  localparam int TOG_O = tog_ofs(NIN, NOUT);

  logic [CFGW-1:0] active;
  logic [NLUT-1:0] lut;
  logic [NCFG-1:0] sel;
  logic [NOUT-1:0] tog;
  logic [NIN-1:0]  ram_sel;
  logic [NOUT-1:0] lut_word;
  logic [NOUT-1:0] nxt;

  minilogix2_cfg #(.NIN(NIN), .NOUT(NOUT)) u_cfg (
    .clk       (clk),
    .rst       (rst),
    .load_en   (bus.i_load_en),
    .load_dat  (bus.i_load_dat),
    .commit    (bus.i_commit),
    .active    (active),
    .cfg_valid (bus.o_cfg_valid),
    .cfg_err   (bus.o_cfg_err),
    .load_out  (bus.o_load_dat)
  );

  assign lut = active[LUT_OFS +: NLUT];
  assign sel = active[SEL_O   +: NCFG];
  assign tog = active[TOG_O   +: NOUT];

  // Feedback taps read the registered outputs, i.e. the value before the edge.
  always_comb begin
    ram_sel = bus.i_input;
    for (int j = 0; j < NCFG; j++)
      if (sel[j]) ram_sel[j] = bus.o_output[j];
  end

  assign lut_word = lut[int'(ram_sel) * NOUT +: NOUT];

  for (genvar k = 0; k < NOUT; k++) begin : g_out
    assign nxt[k] = tog[k] ? (bus.o_output[k] ^ lut_word[k]) : lut_word[k];
  end

  always_ff @(posedge clk or posedge rst)
    if (rst)                                bus.o_output <= '0;
    else if (bus.i_run && bus.o_cfg_valid) bus.o_output <= nxt;

endmodule

// File: tb/tb_minilogix2.sv
// Randomised and directed checks of minilogix2 against a bit-queue model.
module tb_minilogix2;
  import minilogix_pkg::*;

  localparam int NIN  = 4;
  localparam int NOUT = 4;
  localparam int NA   = 1 << NIN;
  localparam int NCFG = (NIN < NOUT) ? NIN : NOUT;
  localparam int NLUT = NOUT * NA;
  localparam int CFGW = NLUT + NCFG + NOUT;

  logic clk = 1'b0;
  logic rst = 1'b1;

  minilogix2_if #(.NIN(NIN), .NOUT(NOUT)) bus ();
  minilogix2 #(.NIN(NIN), .NOUT(NOUT)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: q[0] is the chain MSB (oldest bit still held)
  bit              sh_q[$];
  int              m_cnt;
  bit              m_valid, m_err;
  logic [NOUT-1:0] m_out;
  logic [NOUT-1:0] m_lut [NA];
  logic [NCFG-1:0] m_sel;
  logic [NOUT-1:0] m_tog;

  // Stimulus-side config fields
  logic [NOUT-1:0] w_lut [NA];
  logic [NCFG-1:0] w_sel;
  logic [NOUT-1:0] w_tog;

  function automatic void m_reset();
    sh_q.delete();
    for (int i = 0; i < CFGW; i++) sh_q.push_back(1'b0);
    m_cnt = 0; m_valid = 0; m_err = 0; m_out = '0;
    for (int a = 0; a < NA; a++) m_lut[a] = '0;
    m_sel = '0; m_tog = '0;
  endfunction

  function automatic bit qbit(input int b);
    return sh_q[CFGW-1-b];
  endfunction

  function automatic void m_decode();
    for (int a = 0; a < NA; a++)
      for (int k = 0; k < NOUT; k++) m_lut[a][k] = qbit(a*NOUT + k);
    for (int j = 0; j < NCFG; j++) m_sel[j] = qbit(NLUT + j);
    for (int k = 0; k < NOUT; k++) m_tog[k] = qbit(NLUT + NCFG + k);
  endfunction

  function automatic void m_update(input logic [NIN-1:0] in, input bit run, le, ld, cm);
    logic [NIN-1:0]  a;
    logic [NOUT-1:0] w, o;
    a = in;
    for (int j = 0; j < NCFG; j++) if (m_sel[j]) a[j] = m_out[j];
    w = m_lut[a];
    o = m_out;
    if (run && m_valid)
      for (int k = 0; k < NOUT; k++) o[k] = m_tog[k] ? (m_out[k] ^ w[k]) : w[k];
    m_out = o;
    if (cm) begin
      if (m_cnt == CFGW) begin m_decode(); m_valid = 1; m_err = 0; end
      else m_err = 1;
      m_cnt = le ? 1 : 0;
    end else if (le && m_cnt < CFGW) m_cnt++;
    if (le) begin sh_q.push_back(ld); void'(sh_q.pop_front()); end
  endfunction

  function automatic logic [CFGW-1:0] build();
    logic [CFGW-1:0] w;
    w = '0;
    for (int a = 0; a < NA; a++)
      for (int k = 0; k < NOUT; k++) w[a*NOUT + k] = w_lut[a][k];
    for (int j = 0; j < NCFG; j++) w[NLUT + j] = w_sel[j];
    for (int k = 0; k < NOUT; k++) w[NLUT + NCFG + k] = w_tog[k];
    return w;
  endfunction

  task automatic step(input logic [NIN-1:0] in, input bit run, le, ld, cm);
    bus.i_input = in; bus.i_run = run; bus.i_load_en = le;
    bus.i_load_dat = ld; bus.i_commit = cm;
    @(posedge clk);
    m_update(in, run, le, ld, cm);
    #1;
    chk("out",   bus.o_output,    m_out);
    chk("sdo",   bus.o_load_dat,  sh_q[0]);
    chk("valid", bus.o_cfg_valid, m_valid);
    chk("err",   bus.o_cfg_err,   m_err);
  endtask

  task automatic load_word(input logic [CFGW-1:0] w, input int nbits, input bit run);
    for (int i = CFGW-1; i >= CFGW-nbits; i--)
      step(NIN'($urandom), run, 1'b1, w[i], 1'b0);
  endtask

  task automatic commit_now();
    step(NIN'($urandom), 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  logic [CFGW-1:0] word, ident;
  logic [NOUT-1:0] exp;

  initial begin
    bus.i_input = '0; bus.i_run = 0; bus.i_load_en = 0;
    bus.i_load_dat = 0; bus.i_commit = 0;
    m_reset();
    #12;
    chk("rst_out",   bus.o_output,    0);
    chk("rst_sdo",   bus.o_load_dat,  0);
    chk("rst_valid", bus.o_cfg_valid, 0);
    chk("rst_err",   bus.o_cfg_err,   0);
    @(negedge clk); rst = 1'b0;

    // Identity
    for (int a = 0; a < NA; a++) w_lut[a] = NOUT'(a);
    w_sel = '0; w_tog = '0;
    ident = build();
    load_word(ident, CFGW, 1'b1);
    commit_now();
    chk("ident_valid", bus.o_cfg_valid, 1);
    step(4'h3, 1, 0, 0, 0); chk("ident_3", bus.o_output, 4'h3);
    step(4'hA, 1, 0, 0, 0); chk("ident_A", bus.o_output, 4'hA);
    step(4'hF, 1, 0, 0, 0); chk("ident_F", bus.o_output, 4'hF);

    // Counter via full feedback
    for (int a = 0; a < NA; a++) w_lut[a] = NOUT'(a + 1);
    w_sel = '1; w_tog = '0;
    load_word(build(), CFGW, 1'b0);
    commit_now();
    exp = 4'hF;
    for (int n = 0; n < 16; n++) begin
      step(NIN'($urandom), 1, 0, 0, 0);
      exp = exp + 1'b1;
      chk("count", bus.o_output, exp);
    end
    repeat (3) begin
      step(NIN'($urandom), 0, 0, 0, 0);
      chk("hold", bus.o_output, exp);
    end

    // Toggle mode on bit 0
    for (int a = 0; a < NA; a++) w_lut[a] = 4'h1;
    w_sel = '0; w_tog = 4'h1;
    load_word(build(), CFGW, 1'b0);
    commit_now();
    for (int n = 0; n < 6; n++) begin
      step(NIN'($urandom), 1, 0, 0, 0);
      exp = {3'b000, ~exp[0]};
      chk("toggle", bus.o_output, exp);
    end

    // Short load rejected, then full load accepted
    load_word(ident, CFGW-1, 1'b0);
    commit_now();
    chk("short_err",   bus.o_cfg_err,   1);
    chk("short_valid", bus.o_cfg_valid, 1);
    step(4'h5, 1, 0, 0, 0);
    chk("short_keep", bus.o_output, {3'b000, ~exp[0]});
    load_word(ident, CFGW, 1'b0);
    commit_now();
    chk("full_err", bus.o_cfg_err, 0);
    step(4'h5, 1, 0, 0, 0);
    chk("full_ident", bus.o_output, 4'h5);

    // Chain readback and commit with simultaneous shift
    for (int i = 0; i < CFGW; i++) word[i] = 1'($urandom);
    load_word(word, CFGW, 1'b0);
    for (int k = 0; k < 8; k++) begin
      chk("chain", bus.o_load_dat, word[CFGW-1-k]);
      step(NIN'($urandom), 0, 1, 1'($urandom), 0);
    end
    step(NIN'($urandom), 0, 1, 1'($urandom), 1);
    chk("chain_commit_err", bus.o_cfg_err, 0);
    repeat (4) step(NIN'($urandom), 1, 0, 0, 0);

    // Random traffic
    for (int n = 0; n < 12; n++) begin
      if ($urandom_range(0, 1) == 0) begin
        for (int a = 0; a < NA; a++) w_lut[a] = NOUT'($urandom);
        w_sel = NCFG'($urandom); w_tog = NOUT'($urandom);
        load_word(build(), CFGW, 1'($urandom));
        step(NIN'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
      end
      repeat (25)
        step(NIN'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
             1'($urandom), $urandom_range(0, 15) == 0);
    end

    // Reset mid-load
    load_word(ident, 40, 1'b1);
    @(negedge clk); rst = 1'b1;
    #1;
    chk("mrst_out",   bus.o_output,    0);
    chk("mrst_sdo",   bus.o_load_dat,  0);
    chk("mrst_valid", bus.o_cfg_valid, 0);
    chk("mrst_err",   bus.o_cfg_err,   0);
    m_reset();
    @(negedge clk); rst = 1'b0;
    commit_now();
    chk("mrst_commit_err",   bus.o_cfg_err,   1);
    chk("mrst_commit_valid", bus.o_cfg_valid, 0);
    step(NIN'($urandom), 1, 0, 0, 0);
    chk("mrst_out_idle", bus.o_output, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
